fpmul_seq: RTL and testbench

- Sequential 16-bit floating-point multiplier. Format: 1 sign bit, 8 exponent bits (bias 127), 7 mantissa bits.
- It is the multiplicative counterpart of the team's sequential FP divider and uses the same en/ready handshake, so the two can sit side by side in the arithmetic datapath.
- Significands are multiplied by an iterative shift-add core, then normalised and rounded to nearest-even.
- Latency is constant and independent of the operand values.

---
 rtl/fp16_pkg.sv | 33 +++
 rtl/fpmul_seq_if.sv | 14 +
 rtl/fpmul_seq_fractional_multiplier.sv | 59 +++++
 rtl/fpmul_seq.sv | 119 +++++++++++
 tb/tb_fpmul_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the 1/8/7 floating-point datapath: field widths,
// special encodings, FSM states and operand classification helpers.
package fp16_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 7;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [W-1:0]     QNAN    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [W-1:0] v);
        return (v[W-2:MAN_W] == EXP_INF) && (v[MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [W-1:0] v);
        return (v[W-2:MAN_W] == EXP_INF) && (v[MAN_W-1:0] == '0);
    endfunction

    // Denormal encodings are treated as zero.
    function automatic logic is_zero(input logic [W-1:0] v);
        return v[W-2:MAN_W] == '0;
    endfunction

endpackage

// File: rtl/fpmul_seq_if.sv
// Start/complete handshake and operand/result bus of the sequential FP multiplier.
interface fpmul_seq_if;

    logic [fp16_pkg::W-1:0] x1;
    logic [fp16_pkg::W-1:0] x2;
    logic                   en;
    logic [fp16_pkg::W-1:0] y;
    logic                   ready;
    logic                   busy;

    modport master (output x1, x2, en, input y, ready, busy);
    modport slave  (input x1, x2, en, output y, ready, busy);

endinterface

// File: rtl/fpmul_seq_fractional_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, N steps,
// registered one-cycle done pulse once the full 2N-bit product is held.
module fractional_multiplier #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           done
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     mcand;
    logic [N-1:0]     hi;
    logic [N-1:0]     lo;
    logic [CNT_W-1:0] count;
    logic             running;
    logic [N:0]       sum_c;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        sum_c = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : (N+1)'(0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= multiplicand;
                hi      <= '0;
                lo      <= multiplier;
                count   <= '0;
                running <= 1'b1;
            end else if (running) begin
                hi    <= sum_c[N:1];
                lo    <= {sum_c[0], lo[N-1:1]};
                count <= count + CNT_W'(1);
                if (count == CNT_W'(N - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = {hi, lo};

endmodule

// File: rtl/fpmul_seq.sv
// Sequential 1/8/7 floating-point multiplier with en/ready handshake, fixed
// 10-edge latency, round-to-nearest-even and flush-to-zero on underflow.
module fpmul_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fpmul_seq_if.slave  bus
);

    localparam int unsigned E_W = EXP_W + 2;
    localparam int unsigned P_W = 2 * SIG_W;

    state_t           state;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     y_q;
    logic             ready_q;
    logic             busy_q;

    logic             start_c;
    logic             mul_done;
    logic [P_W-1:0]   prod;

    logic             sign_c;
    logic             p_hi_c;
    logic [MAN_W-1:0] mant_c;
    logic             guard_c;
    logic             sticky_c;
    logic             round_up_c;
    logic [MAN_W:0]   mant_r_c;
    logic signed [E_W-1:0] exp_c;
    logic [W-1:0]     result_c;

    assign start_c = (state == IDLE) && bus.en;

    fractional_multiplier #(.N(SIG_W)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (start_c),
        .multiplicand ({1'b1, bus.x1[MAN_W-1:0]}),
        .multiplier   ({1'b1, bus.x2[MAN_W-1:0]}),
        .product      (prod),
        .done         (mul_done)
    );

    // Normalise the 2.14 product, round to nearest-even and resolve special operands.
    always_comb begin
        sign_c   = a[W-1] ^ b[W-1];
        p_hi_c   = prod[P_W-1];
        mant_c   = prod[P_W-3 -: MAN_W];
        guard_c  = prod[P_W-3-MAN_W];
        sticky_c = |prod[P_W-4-MAN_W:0];
        if (p_hi_c) begin
            mant_c   = prod[P_W-2 -: MAN_W];
            guard_c  = prod[P_W-2-MAN_W];
            sticky_c = |prod[P_W-3-MAN_W:0];
        end
        round_up_c = guard_c & (sticky_c | mant_c[0]);
        mant_r_c   = {1'b0, mant_c} + (MAN_W+1)'(round_up_c);
        exp_c      = $signed(E_W'(a[W-2:MAN_W])) + $signed(E_W'(b[W-2:MAN_W]))
                   - $signed(E_W'(BIAS)) + $signed(E_W'(p_hi_c))
                   + $signed(E_W'(mant_r_c[MAN_W]));

        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) begin
            result_c = QNAN;
        end else if (is_inf(a) || is_inf(b)) begin
            result_c = {sign_c, EXP_INF, MAN_W'(0)};
        end else if (is_zero(a) || is_zero(b)) begin
            result_c = {sign_c, (W-1)'(0)};
        end else if (exp_c >= $signed(E_W'(EXP_INF))) begin
            result_c = {sign_c, EXP_INF, MAN_W'(0)};
        end else if (exp_c <= $signed(E_W'(0))) begin
            result_c = {sign_c, (W-1)'(0)};
        end else begin
            result_c = {sign_c, exp_c[EXP_W-1:0], mant_r_c[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        a      <= bus.x1;
                        b      <= bus.x2;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    y_q     <= result_c;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y     = y_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_fpmul_seq.sv
// Directed bench for fpmul_seq: vectors with hand-computed results, a
// reference model of the number format, and a per-cycle output monitor.
module tb_fpmul_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpmul_seq_if bus();

    fpmul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] y;
        int          due;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    localparam int NV = 17;
    localparam vec_t VECS [NV] = '{
        '{16'h3FC0, 16'h4000, 16'h4040},
        '{16'h3FC0, 16'h3FC0, 16'h4010},
        '{16'hC040, 16'h4000, 16'hC0C0},
        '{16'h3FC1, 16'h3FC1, 16'h4012},
        '{16'h3F81, 16'h3F81, 16'h3F82},
        '{16'h7F00, 16'h4000, 16'h7F80},
        '{16'h0000, 16'h7F80, 16'hFFFF},
        '{16'h8000, 16'h3F80, 16'h8000},
        '{16'h0080, 16'h0080, 16'h0000},
        '{16'h7FC0, 16'h3F80, 16'hFFFF},
        '{16'h7F80, 16'hBF80, 16'hFF80},
        '{16'h3F81, 16'h3FC0, 16'h3FC2},
        '{16'h3F83, 16'h3FC0, 16'h3FC4},
        '{16'h3FB5, 16'h3FB5, 16'h4000},
        '{16'h3FFF, 16'h3FFF, 16'h407E},
        '{16'h0055, 16'hBF80, 16'h8000},
        '{16'h8001, 16'h7F80, 16'hFFFF}
    };

    exp_t        q[$];
    int          cyc      = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          last_acc = 0;
    logic [15:0] last_y   = 16'h0000;
    bit          mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Reference: exact integer product, remainder-vs-half rounding, then range checks.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, p, e, sh, qv, rem, half;
        logic s, na, nb, ia, ib, za, zb;
        s  = a[15] ^ b[15];
        ea = int'({24'd0, a[14:7]});
        eb = int'({24'd0, b[14:7]});
        ma = int'({25'd0, a[6:0]});
        mb = int'({25'd0, b[6:0]});
        na = (ea == 255) && (ma != 0);
        nb = (eb == 255) && (mb != 0);
        ia = (ea == 255) && (ma == 0);
        ib = (eb == 255) && (mb == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (ia && zb) || (ib && za)) return 16'hFFFF;
        if (ia || ib) return {s, 8'hFF, 7'h00};
        if (za || zb) return {s, 15'h0000};
        p = (128 + ma) * (128 + mb);
        e = ea + eb - 127;
        if (p >= 32768) begin
            sh = 8;
            e  = e + 1;
        end else begin
            sh = 7;
        end
        qv   = p >> sh;
        rem  = p - (qv << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (qv % 2) == 1)) qv = qv + 1;
        if (qv == 256) begin
            qv = 128;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        return {s, 8'(e), 7'(qv)};
    endfunction

    // Output monitor: result and pulse timing on the due cycle, idle/busy/hold elsewhere.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (q.size() != 0 && cyc == q[0].due) begin
                chk("ready_pulse", 16'(bus.ready), 16'h0001);
                chk("y_result", bus.y, q[0].y);
                chk("busy_at_done", 16'(bus.busy), 16'h0000);
                last_y = q[0].y;
                void'(q.pop_front());
            end else begin
                chk("ready_idle", 16'(bus.ready), 16'h0000);
                chk("y_hold", bus.y, last_y);
                if (q.size() != 0 && cyc >= q[0].due - 10)
                    chk("busy_active", 16'(bus.busy), 16'h0001);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] lit);
        exp_t e;
        @(negedge clk);
        bus.x1 = a;
        bus.x2 = b;
        bus.en = 1'b1;
        chk("model_pin", model(a, b), lit);
        last_acc = cyc + 1;
        e.y   = lit;
        e.due = cyc + 11;
        q.push_back(e);
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.x1 = 16'h0000;
        bus.x2 = 16'h0000;
        bus.en = 1'b0;
        #2;
        chk("reset_y", bus.y, 16'h0000);
        chk("reset_ready", 16'(bus.ready), 16'h0000);
        chk("reset_busy", 16'(bus.busy), 16'h0000);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // First vector, then an ignored en at k+3 and a back-to-back start at k+11.
        issue(VECS[0].a, VECS[0].b, VECS[0].r);
        wait_until(last_acc + 2);
        bus.x1 = 16'h7F80;
        bus.x2 = 16'h0000;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_until(last_acc + 9);

        for (int i = 1; i < NV; i++) begin
            issue(VECS[i].a, VECS[i].b, VECS[i].r);
            wait_until(last_acc + 9);
        end
        wait_until(last_acc + 14);

        // Abort mid-operation: outputs clear at once and no result follows.
        issue(16'h3FC0, 16'h3FC0, 16'h4010);
        wait_until(last_acc + 4);
        rst = 1'b0;
        #1;
        chk("abort_y", bus.y, 16'h0000);
        chk("abort_ready", 16'(bus.ready), 16'h0000);
        chk("abort_busy", 16'(bus.busy), 16'h0000);
        q.delete();
        last_y = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);

        issue(16'hC040, 16'h4000, 16'hC0C0);
        wait_until(last_acc + 14);
        chk("queue_drained", 16'(q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
